// File: rtl/ctrl_seg_pkg.sv
// Shared definitions for the control-segment pipeline registers.
// Holds default widths, the MEM/WB control-bundle bit map, the per-boundary
// flush value and the per-edge operation code used between pipe and stage.
package ctrl_seg_pkg;

  localparam int CTRL_W_DEF = 8;
  localparam int DEPTH_DEF  = 1;

  // MEM/WB control bundle bit positions
  localparam int REG_WRITE_EN = 0;
  localparam int CSR_WRITE_EN = 1;

  // Value a boundary register holds for a bubble/flushed slot: all write
  // enables low, so an invalid slot can never commit architectural state.
  localparam logic [CTRL_W_DEF-1:0] FLUSH_VAL_DEF = '0;

  // What every stage does on the coming edge
  typedef enum logic [1:0] {
    SEG_SHIFT = 2'd0,
    SEG_HOLD  = 2'd1,
    SEG_FLUSH = 2'd2
  } seg_op_e;

endpackage

// File: rtl/ctrl_seg_if.sv
// Bus bundle of the control-segment pipe: pipeline controls, control bundle
// in/out with valid bits, pending-flush status and the event counters.
// master = upstream/CSR side driving controls; slave = the segment register.
interface ctrl_seg_if
  import ctrl_seg_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = 16
);
  logic              bubble;
  logic              flush;
  logic [CTRL_W-1:0] ctrl_in;
  logic              valid_in;
  logic              clr_cnt;
  logic [CTRL_W-1:0] ctrl_out;
  logic              valid_out;
  logic              flush_pending;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output bubble, flush, ctrl_in, valid_in, clr_cnt,
    input  ctrl_out, valid_out, flush_pending, stall_cnt, flush_cnt
  );

  modport slave (
    input  bubble, flush, ctrl_in, valid_in, clr_cnt,
    output ctrl_out, valid_out, flush_pending, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_seg_stage.sv
// One control-segment stage: a CTRL_W+1-bit flop (bundle + valid) with hold,
// flush and load. Ports: clk/rst, op (shift/hold/flush), d_* from the
// previous stage, q_* to the next one. An invalid slot always holds FLUSH_VAL.
module ctrl_seg_stage
  import ctrl_seg_pkg::*;
#(
  parameter int                CTRL_W    = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  seg_op_e           op,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic              d_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic              q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctrl  <= FLUSH_VAL;
      q_valid <= 1'b0;
    end else begin
      case (op)
        SEG_FLUSH: begin
          q_ctrl  <= FLUSH_VAL;
          q_valid <= 1'b0;
        end
        SEG_SHIFT: begin
          // Masking keeps garbage from ever entering on an invalid load
          q_ctrl  <= d_valid ? d_ctrl : FLUSH_VAL;
          q_valid <= d_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seg_pipe.sv
// DEPTH-stage control-signal segment register with per-stage valid, flush,
// optional deferral of a flush that lands on a bubble, and saturating
// stall/flush counters. Ports: clk, rst (async, active-high), seg (slave).
module ctrl_seg_pipe
  import ctrl_seg_pkg::*;
#(
  parameter int                CTRL_W     = CTRL_W_DEF,
  parameter int                DEPTH      = DEPTH_DEF,   // legal 1..4
  parameter logic [CTRL_W-1:0] FLUSH_VAL  = '0,
  parameter bit                FLUSH_PEND = 1'b1,
  parameter int                CNT_W      = 16
) (
  input logic     clk,
  input logic     rst,
  ctrl_seg_if.slave seg
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seg_op_e               op;
  logic                  pend_q;
  logic                  do_flush;
  logic [CNT_W-1:0]      stall_q;
  logic [CNT_W-1:0]      flush_q;
  logic [DEPTH:0][CTRL_W-1:0] st_ctrl;
  logic [DEPTH:0]             st_vld;

  // A bubble wins over any flush; a held flush fires on the first free edge
  assign do_flush = !seg.bubble && (seg.flush || pend_q);

  always_comb begin
    op = SEG_SHIFT;
    if (seg.bubble)    op = SEG_HOLD;
    else if (do_flush) op = SEG_FLUSH;
  end

  assign st_ctrl[0] = seg.ctrl_in;
  assign st_vld[0]  = seg.valid_in;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    ctrl_seg_stage #(
      .CTRL_W    (CTRL_W),
      .FLUSH_VAL (FLUSH_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .op      (op),
      .d_ctrl  (st_ctrl[i]),
      .d_valid (st_vld[i]),
      .q_ctrl  (st_ctrl[i+1]),
      .q_valid (st_vld[i+1])
    );
  end

  // Pending flush: armed only during a bubble, always consumed once the
  // bubble ends (either it fires now or nothing was armed).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (seg.bubble) begin
      if (FLUSH_PEND && seg.flush) pend_q <= 1'b1;
    end else begin
      pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (seg.clr_cnt) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (seg.bubble && stall_q != CNT_MAX) stall_q <= stall_q + CNT_W'(1);
      if (do_flush && flush_q != CNT_MAX)   flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign seg.ctrl_out      = st_ctrl[DEPTH];
  assign seg.valid_out     = st_vld[DEPTH];
  assign seg.flush_pending = pend_q;
  assign seg.stall_cnt     = stall_q;
  assign seg.flush_cnt     = flush_q;

endmodule

// File: tb/tb_ctrl_seg_pipe.sv
`timescale 1ns/1ps
module tb_ctrl_seg_pipe;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       bubble, flush, valid_in, clr_cnt;
  logic [7:0] ctrl_in;

  always #5 clk = ~clk;

  ctrl_seg_if #(.CTRL_W(8), .CNT_W(4))  if0 ();
  ctrl_seg_if #(.CTRL_W(8), .CNT_W(16)) if1 ();
  ctrl_seg_if #(.CTRL_W(8), .CNT_W(8))  if2 ();

  assign if0.bubble = bubble;  assign if0.flush = flush;  assign if0.ctrl_in = ctrl_in;
  assign if0.valid_in = valid_in;  assign if0.clr_cnt = clr_cnt;
  assign if1.bubble = bubble;  assign if1.flush = flush;  assign if1.ctrl_in = ctrl_in;
  assign if1.valid_in = valid_in;  assign if1.clr_cnt = clr_cnt;
  assign if2.bubble = bubble;  assign if2.flush = flush;  assign if2.ctrl_in = ctrl_in;
  assign if2.valid_in = valid_in;  assign if2.clr_cnt = clr_cnt;

  ctrl_seg_pipe #(.CTRL_W(8), .DEPTH(3), .FLUSH_VAL(8'h00), .FLUSH_PEND(1'b1), .CNT_W(4))
    u_dut0 (.clk(clk), .rst(rst), .seg(if0));
  ctrl_seg_pipe #(.CTRL_W(8), .DEPTH(2), .FLUSH_VAL(8'h5A), .FLUSH_PEND(1'b0), .CNT_W(16))
    u_dut1 (.clk(clk), .rst(rst), .seg(if1));
  ctrl_seg_pipe #(.CTRL_W(8), .DEPTH(1), .FLUSH_VAL(8'hC3), .FLUSH_PEND(1'b1), .CNT_W(8))
    u_dut2 (.clk(clk), .rst(rst), .seg(if2));

  logic [7:0]  o_ctrl  [ND];
  logic        o_vld   [ND];
  logic        o_pend  [ND];
  logic [15:0] o_stall [ND];
  logic [15:0] o_fcnt  [ND];

  assign o_ctrl[0] = if0.ctrl_out;  assign o_vld[0] = if0.valid_out;  assign o_pend[0] = if0.flush_pending;
  assign o_stall[0] = {12'b0, if0.stall_cnt};  assign o_fcnt[0] = {12'b0, if0.flush_cnt};
  assign o_ctrl[1] = if1.ctrl_out;  assign o_vld[1] = if1.valid_out;  assign o_pend[1] = if1.flush_pending;
  assign o_stall[1] = if1.stall_cnt;  assign o_fcnt[1] = if1.flush_cnt;
  assign o_ctrl[2] = if2.ctrl_out;  assign o_vld[2] = if2.valid_out;  assign o_pend[2] = if2.flush_pending;
  assign o_stall[2] = {8'b0, if2.stall_cnt};  assign o_fcnt[2] = {8'b0, if2.flush_cnt};

  // Reference model: each pipe is a list of slots, slot 0 youngest, the slot
  // at index depth-1 is what leaves the pipe.
  int         m_depth   [ND];
  bit         m_pend_en [ND];
  logic [7:0] m_fval    [ND];
  int         m_max     [ND];
  logic [7:0] m_ctrl    [ND][4];
  bit         m_vld     [ND][4];
  bit         m_pend    [ND];
  int         m_stall   [ND];
  int         m_fcnt    [ND];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 4; k++) begin
        m_ctrl[d][k] = m_fval[d];
        m_vld[d][k]  = 1'b0;
      end
      m_pend[d]  = 1'b0;
      m_stall[d] = 0;
      m_fcnt[d]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      bit flushed;
      flushed = 1'b0;
      if (bubble) begin
        if (flush && m_pend_en[d]) m_pend[d] = 1'b1;
      end else if (flush || m_pend[d]) begin
        for (int k = 0; k < 4; k++) begin
          m_ctrl[d][k] = m_fval[d];
          m_vld[d][k]  = 1'b0;
        end
        m_pend[d] = 1'b0;
        flushed   = 1'b1;
      end else begin
        for (int k = 3; k > 0; k--) begin
          m_ctrl[d][k] = m_ctrl[d][k-1];
          m_vld[d][k]  = m_vld[d][k-1];
        end
        m_ctrl[d][0] = valid_in ? ctrl_in : m_fval[d];
        m_vld[d][0]  = valid_in;
      end
      if (clr_cnt) begin
        m_stall[d] = 0;
        m_fcnt[d]  = 0;
      end else begin
        if (bubble && m_stall[d] < m_max[d]) m_stall[d]++;
        if (flushed && m_fcnt[d] < m_max[d])  m_fcnt[d]++;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      check_val($sformatf("d%0d ctrl_out", d), {24'b0, o_ctrl[d]}, {24'b0, m_ctrl[d][m_depth[d]-1]});
      check_val($sformatf("d%0d valid_out", d), {31'b0, o_vld[d]}, {31'b0, m_vld[d][m_depth[d]-1]});
      check_val($sformatf("d%0d flush_pending", d), {31'b0, o_pend[d]}, {31'b0, m_pend[d]});
      check_val($sformatf("d%0d stall_cnt", d), {16'b0, o_stall[d]}, m_stall[d]);
      check_val($sformatf("d%0d flush_cnt", d), {16'b0, o_fcnt[d]}, m_fcnt[d]);
    end
  endtask

  task automatic set_in(input bit b, input bit f, input bit v, input logic [7:0] c, input bit clr);
    bubble = b;  flush = f;  valid_in = v;  ctrl_in = c;  clr_cnt = clr;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset raised and dropped between two edges; outputs checked with no edge
  task automatic async_reset();
    #3 rst = 1'b1;
    model_reset();
    #1 check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    m_depth   = '{3, 2, 1};
    m_pend_en = '{1'b1, 1'b0, 1'b1};
    m_fval    = '{8'h00, 8'h5A, 8'hC3};
    m_max     = '{15, 65535, 255};

    rst = 1'b1;
    set_in(0, 0, 0, 8'h00, 0);
    model_reset();
    #2 check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-stream with a pending flush armed
    for (int i = 0; i < 4; i++) begin set_in(0, 0, 1, 8'hA5, 0); step(); end
    set_in(1, 1, 1, 8'hA5, 0); step();
    check_val("pend armed before reset", {31'b0, o_pend[0]}, 32'd1);
    async_reset();
    check_val("rst ctrl_out async", {24'b0, o_ctrl[0]}, 32'h00);
    check_val("rst pend cleared", {31'b0, o_pend[0]}, 32'd0);

    // Latency through the 3-deep pipe
    set_in(0, 0, 1, 8'h11, 0); step();
    set_in(0, 0, 1, 8'h22, 0); step();
    set_in(0, 0, 1, 8'h33, 0); step();
    check_val("lat edge3", {24'b0, o_ctrl[0]}, 32'h11);
    set_in(0, 0, 0, 8'hFF, 0); step();
    check_val("lat edge4", {24'b0, o_ctrl[0]}, 32'h22);
    step();
    check_val("lat edge5", {24'b0, o_ctrl[0]}, 32'h33);
    step();
    check_val("invalid in -> flush val", {24'b0, o_ctrl[0]}, 32'h00);
    check_val("invalid in -> valid 0", {31'b0, o_vld[0]}, 32'd0);

    // Bubble hold on the 2-deep pipe, counters cleared at the first load
    set_in(0, 0, 1, 8'h22, 1); step();
    set_in(0, 0, 1, 8'h11, 0); step();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 8'h77, 0); step();
      check_val("bubble hold", {24'b0, o_ctrl[1]}, 32'h22);
    end
    check_val("stall_cnt 3", {16'b0, o_stall[1]}, 32'd3);
    set_in(0, 0, 1, 8'h77, 0); step();
    check_val("shift after bubble", {24'b0, o_ctrl[1]}, 32'h11);

    // Flush landing on a bubble: deferred on d0, dropped on d1
    set_in(1, 0, 0, 8'h00, 1); step();
    set_in(1, 1, 1, 8'h44, 0); step();
    set_in(1, 0, 1, 8'h44, 0); step();
    set_in(1, 0, 1, 8'h44, 0); step();
    check_val("pend held", {31'b0, o_pend[0]}, 32'd1);
    check_val("contents kept d0", {31'b0, o_vld[0]}, 32'd1);
    set_in(0, 0, 1, 8'h44, 0); step();
    check_val("deferred flush valid", {31'b0, o_vld[0]}, 32'd0);
    check_val("deferred flush cnt", {16'b0, o_fcnt[0]}, 32'd1);
    check_val("dropped flush cnt", {16'b0, o_fcnt[1]}, 32'd0);
    check_val("dropped flush survives", {31'b0, o_vld[1]}, 32'd1);

    // Pending plus fresh flush counts once
    set_in(1, 1, 1, 8'h55, 0); step();
    set_in(0, 1, 1, 8'h55, 0); step();
    check_val("pend+flush once", {16'b0, o_fcnt[0]}, 32'd2);

    // Saturation and clear priority on the 4-bit counters
    set_in(0, 0, 0, 8'h00, 1); step();
    for (int i = 0; i < 20; i++) begin set_in(1, 0, 1, 8'h66, 0); step(); end
    check_val("stall sat", {16'b0, o_stall[0]}, 32'd15);
    set_in(1, 0, 1, 8'h66, 1); step();
    check_val("clr beats inc", {16'b0, o_stall[0]}, 32'd0);
    set_in(1, 0, 1, 8'h66, 0); step();
    check_val("count after clr", {16'b0, o_stall[0]}, 32'd1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(99) < 25, $urandom_range(99) < 10, $urandom_range(99) < 70,
             8'($urandom), $urandom_range(99) < 3);
      step();
      if ($urandom_range(499) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
